// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Control unit for the 5-stage core. Decodes D into a control
//            bundle, carries it through the X/M/W registers, handles load-use
//            stalls, branch flushes and the multdiv start/ready handshake.
//            Optional perf counters are enabled with CTRL_PIPE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int OP_W    = 5,
    parameter int ALUOP_W = 5,
    parameter int REG_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [OP_W-1:0]    in_op,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic               flush,
    input  logic               md_ready,
    output logic               stall,
    output logic               md_start,
    output logic               x_valid,
    output logic               x_aluinb,
    output logic               x_sub,
    output logic               x_j,
    output logic               x_bne,
    output logic               x_jal,
    output logic               x_jr,
    output logic               x_bex,
    output logic               x_blt,
    output logic               x_setx,
    output logic               x_md,
    output logic               m_valid,
    output logic               m_dmwe,
    output logic               m_rwd,
    output logic               w_valid,
    output logic               w_rwe,
    output logic [REG_W-1:0]   w_waddr
`ifdef CTRL_PIPE_STATS_EN
    ,
    output logic [31:0]        perf_ld_stalls,
    output logic [31:0]        perf_md_stalls
`endif
);

    localparam logic [OP_W-1:0]    c_op_rtype = OP_W'(0);
    localparam logic [OP_W-1:0]    c_op_j     = OP_W'(1);
    localparam logic [OP_W-1:0]    c_op_bne   = OP_W'(2);
    localparam logic [OP_W-1:0]    c_op_jal   = OP_W'(3);
    localparam logic [OP_W-1:0]    c_op_jr    = OP_W'(4);
    localparam logic [OP_W-1:0]    c_op_addi  = OP_W'(5);
    localparam logic [OP_W-1:0]    c_op_blt   = OP_W'(6);
    localparam logic [OP_W-1:0]    c_op_sw    = OP_W'(7);
    localparam logic [OP_W-1:0]    c_op_lw    = OP_W'(8);
    localparam logic [OP_W-1:0]    c_op_setx  = OP_W'(21);
    localparam logic [OP_W-1:0]    c_op_bex   = OP_W'(22);
    localparam logic [ALUOP_W-1:0] c_alu_mul  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] c_alu_div  = ALUOP_W'(7);
    localparam logic [REG_W-1:0]   c_reg_link   = '1;
    localparam logic [REG_W-1:0]   c_reg_status = {{(REG_W-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic             valid;
        logic             aluinb;
        logic             sub;
        logic             j;
        logic             bne;
        logic             jal;
        logic             jr;
        logic             bex;
        logic             blt;
        logic             setx;
        logic             md;
        logic             dmwe;
        logic             rwd;
        logic             rwe;
        logic [REG_W-1:0] waddr;
    } ctrl_t;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    ctrl_t            r_x;
    logic             r_m_valid, r_m_dmwe, r_m_rwd, r_m_rwe;
    logic [REG_W-1:0] r_m_waddr;
    logic             r_w_valid, r_w_rwe;
    logic [REG_W-1:0] r_w_waddr;

    ctrl_t            w_dec;
    logic             w_is_r, w_is_j, w_is_bne, w_is_jal, w_is_jr, w_is_addi;
    logic             w_is_blt, w_is_sw, w_is_lw, w_is_setx, w_is_bex;
    logic             w_imm_b, w_rs_read, w_rt_read, w_load_use;
    logic [REG_W-1:0] w_dest;
    logic             w_busy, w_md_req, w_m_from_x, w_x_hold, w_x_load;

    assign w_is_r    = (in_op == c_op_rtype);
    assign w_is_j    = (in_op == c_op_j);
    assign w_is_bne  = (in_op == c_op_bne);
    assign w_is_jal  = (in_op == c_op_jal);
    assign w_is_jr   = (in_op == c_op_jr);
    assign w_is_addi = (in_op == c_op_addi);
    assign w_is_blt  = (in_op == c_op_blt);
    assign w_is_sw   = (in_op == c_op_sw);
    assign w_is_lw   = (in_op == c_op_lw);
    assign w_is_setx = (in_op == c_op_setx);
    assign w_is_bex  = (in_op == c_op_bex);

    assign w_imm_b   = w_is_addi | w_is_sw | w_is_lw;
    assign w_rs_read = ~(w_is_j | w_is_jal | w_is_setx | w_is_bex);
    assign w_rt_read = w_is_r | w_is_bne | w_is_blt | w_is_sw;
    assign w_dest    = w_is_jal ? c_reg_link : (w_is_setx ? c_reg_status : in_rd);

    always_comb begin
        w_dec = '0;
        if (in_valid) begin
            w_dec.valid  = 1'b1;
            w_dec.aluinb = w_imm_b;
            w_dec.sub    = ~w_imm_b;
            w_dec.j      = w_is_j;
            w_dec.bne    = w_is_bne;
            w_dec.jal    = w_is_jal;
            w_dec.jr     = w_is_jr;
            w_dec.bex    = w_is_bex;
            w_dec.blt    = w_is_blt;
            w_dec.setx   = w_is_setx;
            w_dec.md     = w_is_r & ((in_aluop == c_alu_mul) | (in_aluop == c_alu_div));
            w_dec.dmwe   = w_is_sw;
            w_dec.rwd    = w_is_lw;
            w_dec.waddr  = w_dest;
            // Writes to r0 are dropped at decode so no later stage sees them.
            w_dec.rwe    = (w_is_r | w_is_addi | w_is_lw | w_is_jal | w_is_setx)
                           & (w_dest != '0);
        end
    end

    // A load in X is identified by rwd; rwe already excludes r0.
    assign w_load_use = in_valid & r_x.valid & r_x.rwd & r_x.rwe &
                        ((w_rs_read & (r_x.waddr == in_rs)) |
                         (w_rt_read & (r_x.waddr == in_rt)));

    assign w_busy   = (r_state == S_MD_BUSY);
    assign w_md_req = (r_state == S_IDLE) & r_x.valid & r_x.md;

    // The mul/div stays in X from the start cycle until the ready edge;
    // when it leaves, D is still held by stall, so X refills with a bubble.
    assign w_x_hold   = w_md_req | (w_busy & ~md_ready);
    assign w_m_from_x = ((r_state == S_IDLE) & ~w_md_req) | (w_busy & md_ready);
    assign w_x_load   = (r_state == S_IDLE) & ~w_md_req & ~flush & ~w_load_use;

    assign md_start = ~reset & w_md_req;
    assign stall    = ~reset & (w_busy | (~flush & w_load_use));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_m_valid <= 1'b0;
            r_m_dmwe  <= 1'b0;
            r_m_rwd   <= 1'b0;
            r_m_rwe   <= 1'b0;
            r_m_waddr <= '0;
            r_w_valid <= 1'b0;
            r_w_rwe   <= 1'b0;
            r_w_waddr <= '0;
        end else begin
            case (r_state)
                S_IDLE:    if (w_md_req) r_state <= S_MD_BUSY;
                S_MD_BUSY: if (md_ready) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            if (w_x_load)
                r_x <= w_dec;
            else if (!w_x_hold)
                r_x <= '0;

            if (w_m_from_x) begin
                r_m_valid <= r_x.valid;
                r_m_dmwe  <= r_x.dmwe;
                r_m_rwd   <= r_x.rwd;
                r_m_rwe   <= r_x.rwe;
                r_m_waddr <= r_x.waddr;
            end else begin
                r_m_valid <= 1'b0;
                r_m_dmwe  <= 1'b0;
                r_m_rwd   <= 1'b0;
                r_m_rwe   <= 1'b0;
                r_m_waddr <= '0;
            end

            r_w_valid <= r_m_valid;
            r_w_rwe   <= r_m_rwe;
            r_w_waddr <= r_m_waddr;
        end
    end

    assign x_valid  = r_x.valid;
    assign x_aluinb = r_x.aluinb;
    assign x_sub    = r_x.sub;
    assign x_j      = r_x.j;
    assign x_bne    = r_x.bne;
    assign x_jal    = r_x.jal;
    assign x_jr     = r_x.jr;
    assign x_bex    = r_x.bex;
    assign x_blt    = r_x.blt;
    assign x_setx   = r_x.setx;
    assign x_md     = r_x.md;
    assign m_valid  = r_m_valid;
    assign m_dmwe   = r_m_dmwe;
    assign m_rwd    = r_m_rwd;
    assign w_valid  = r_w_valid;
    assign w_rwe    = r_w_rwe;
    assign w_waddr  = r_w_waddr;

`ifdef CTRL_PIPE_STATS_EN
    logic [31:0] r_ld_cnt, r_md_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ld_cnt <= '0;
            r_md_cnt <= '0;
        end else begin
            if (~w_busy & ~flush & w_load_use & (r_ld_cnt != '1))
                r_ld_cnt <= r_ld_cnt + 32'd1;
            if (w_busy & (r_md_cnt != '1))
                r_md_cnt <= r_md_cnt + 32'd1;
        end
    end

    assign perf_ld_stalls = r_ld_cnt;
    assign perf_md_stalls = r_md_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Directed and randomized bench for ctrl_pipe against a reference
//            model of the pipeline built from the decode and hazard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid, aluinb, sub, j, bne, jal, jr, bex, blt, setx, md;
        logic       dmwe, rwd, rwe;
        logic [4:0] waddr;
    } bund_t;

    logic       clk = 1'b0;
    logic       reset, in_valid, flush, md_ready;
    logic [4:0] in_op, in_aluop, in_rd, in_rs, in_rt;
    logic       stall, md_start;
    logic       x_valid, x_aluinb, x_sub, x_j, x_bne, x_jal, x_jr, x_bex, x_blt, x_setx, x_md;
    logic       m_valid, m_dmwe, m_rwd, w_valid, w_rwe;
    logic [4:0] w_waddr;

    int    errors = 0;
    int    checks = 0;
    bit    chk_en = 1'b0;
    bit    last_stall = 1'b0;
    bund_t mx, mm, mw;
    bit    mbusy;
    logic [4:0] op_tab [0:14];

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_aluop(in_aluop), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .flush(flush), .md_ready(md_ready), .stall(stall), .md_start(md_start),
        .x_valid(x_valid), .x_aluinb(x_aluinb), .x_sub(x_sub), .x_j(x_j),
        .x_bne(x_bne), .x_jal(x_jal), .x_jr(x_jr), .x_bex(x_bex), .x_blt(x_blt),
        .x_setx(x_setx), .x_md(x_md), .m_valid(m_valid), .m_dmwe(m_dmwe),
        .m_rwd(m_rwd), .w_valid(w_valid), .w_rwe(w_rwe), .w_waddr(w_waddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction-level meaning of each opcode.
    function automatic bund_t model_decode(input logic v, input logic [4:0] op,
                                           input logic [4:0] aluop, input logic [4:0] rd);
        bund_t b;
        bit    is_r, is_addi, is_sw, is_lw, is_jal, is_setx;
        b = '0;
        if (!v) return b;
        is_r = (op == 0); is_addi = (op == 5); is_sw = (op == 7);
        is_lw = (op == 8); is_jal = (op == 3); is_setx = (op == 21);
        b.valid  = 1'b1;
        b.aluinb = is_addi || is_sw || is_lw;
        b.sub    = !b.aluinb;
        b.j      = (op == 1);
        b.bne    = (op == 2);
        b.jal    = is_jal;
        b.jr     = (op == 4);
        b.blt    = (op == 6);
        b.setx   = is_setx;
        b.bex    = (op == 22);
        b.md     = is_r && (aluop == 6 || aluop == 7);
        b.dmwe   = is_sw;
        b.rwd    = is_lw;
        b.waddr  = is_jal ? 5'd31 : (is_setx ? 5'd30 : rd);
        b.rwe    = (is_r || is_addi || is_lw || is_jal || is_setx) && (b.waddr != 0);
        return b;
    endfunction

    function automatic bit reads_rs(input logic [4:0] op);
        return !(op == 1 || op == 3 || op == 21 || op == 22);
    endfunction

    function automatic bit reads_rt(input logic [4:0] op);
        return (op == 0 || op == 2 || op == 6 || op == 7);
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit lu, mds, stl;
        @(negedge clk);
        lu  = in_valid && mx.valid && mx.rwd && mx.rwe &&
              ((reads_rs(in_op) && mx.waddr == in_rs) || (reads_rt(in_op) && mx.waddr == in_rt));
        mds = !reset && !mbusy && mx.valid && mx.md;
        stl = !reset && (mbusy || (!flush && lu));
        if (chk_en) begin
            check("stall", 32'(stall), 32'(stl));
            check("md_start", 32'(md_start), 32'(mds));
            check("x_bundle", 32'({x_valid, x_aluinb, x_sub, x_j, x_bne, x_jal, x_jr, x_bex,
                                   x_blt, x_setx, x_md}),
                  32'({mx.valid, mx.aluinb, mx.sub, mx.j, mx.bne, mx.jal, mx.jr, mx.bex,
                       mx.blt, mx.setx, mx.md}));
            check("m_bundle", 32'({m_valid, m_dmwe, m_rwd}), 32'({mm.valid, mm.dmwe, mm.rwd}));
            check("w_bundle", 32'({w_valid, w_rwe, w_waddr}), 32'({mw.valid, mw.rwe, mw.waddr}));
        end
        last_stall = stl;
        @(posedge clk);
        if (reset) begin
            mx = '0; mm = '0; mw = '0; mbusy = 1'b0;
        end else if (mbusy) begin
            mw = mm;
            if (md_ready) begin
                mm = mx; mx = '0; mbusy = 1'b0;
            end else begin
                mm = '0;
            end
        end else if (mds) begin
            mw = mm; mm = '0; mbusy = 1'b1;
        end else begin
            mw = mm; mm = mx;
            mx = (flush || lu) ? bund_t'('0) : model_decode(in_valid, in_op, in_aluop, in_rd);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Present an instruction in D and hold it until it is accepted.
    task automatic issue(input logic [4:0] op, input logic [4:0] aluop,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        int n;
        in_valid = 1'b1; in_op = op; in_aluop = aluop; in_rd = rd; in_rs = rs; in_rt = rt;
        step();
        n = 0;
        while (last_stall && n < 40) begin
            step();
            n++;
        end
        if (last_stall) check("issue_bound", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        op_tab = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                   5'd7, 5'd8, 5'd8, 5'd21, 5'd22, 5'd9, 5'd31};
        mx = '0; mm = '0; mw = '0; mbusy = 1'b0;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; md_ready = 1'b0;
        in_op = '0; in_aluop = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        #1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        issue(5'd5, 5'd0, 5'd3, 5'd1, 5'd0);          // addi r3
        idle(4);

        issue(5'd8, 5'd0, 5'd5, 5'd1, 5'd0);          // lw r5
        issue(5'd0, 5'd0, 5'd6, 5'd5, 5'd2);          // add r6,r5,r2
        idle(4);

        issue(5'd0, 5'd6, 5'd7, 5'd1, 5'd2);          // mul, ready 4 cycles after start
        md_ready = 1'b0;
        repeat (4) step();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        idle(3);

        issue(5'd8, 5'd0, 5'd5, 5'd1, 5'd0);          // lw r5, then flush over load-use
        in_valid = 1'b1; in_op = 5'd0; in_aluop = 5'd0; in_rd = 5'd6; in_rs = 5'd5; in_rt = 5'd2;
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(3);

        issue(5'd3, 5'd0, 5'd0, 5'd0, 5'd0);          // jal
        issue(5'd21, 5'd0, 5'd0, 5'd0, 5'd0);         // setx
        issue(5'd0, 5'd0, 5'd0, 5'd1, 5'd2);          // add r0
        idle(4);

        issue(5'd0, 5'd7, 5'd4, 5'd1, 5'd2);          // div, then reset while busy
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(2);
        issue(5'd0, 5'd6, 5'd4, 5'd1, 5'd2);
        step(); step();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        idle(3);

        repeat (3000) begin
            if (!last_stall) begin
                in_valid = ($urandom % 10) != 0;
                in_op    = op_tab[$urandom_range(0, 14)];
                in_aluop = 5'($urandom_range(0, 8));
                in_rd    = 5'($urandom_range(0, 7));
                in_rs    = 5'($urandom_range(0, 7));
                in_rt    = 5'($urandom_range(0, 7));
            end
            md_ready = ($urandom % 3) == 0;
            flush    = (($urandom % 8) == 0) && !(!mbusy && mx.valid && mx.md);
            reset    = ($urandom % 250) == 0;
            step();
        end
        reset = 1'b0; flush = 1'b0; md_ready = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
